// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings
package alu_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_NOP = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'h2;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'h3;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'h4;

endpackage

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared pipeline constants and forwarding helpers
package id_ex_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  xword_t;
    typedef logic [1:0]       fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    // x0 is hardwired, so a producer targeting it never matches
    function automatic logic fwd_hit(input logic we, input reg_idx_t rd, input reg_idx_t rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - per-source operand forwarding mux
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_data,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  operand
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (fwd_hit(mem_reg_write, mem_rd, rs)) begin
            sel = FWD_MEM;
        end else if (fwd_hit(wb_reg_write, wb_rd, rs)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        case (sel)
            FWD_MEM: operand = mem_result;
            FWD_WB:  operand = wb_result;
            default: operand = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and flush
module id_ex_stage
    import alu_pkg::*;
    import id_ex_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_use_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic [REG_W-1:0]   mem_rd,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               mem_reg_write,
    input  logic               wb_reg_write,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [XLEN-1:0]    wb_result,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [XLEN-1:0]    alu_data1,
    output logic [XLEN-1:0]    alu_data2,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               load_use_stall
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic [REG_W-1:0] held_rs1;
    logic [REG_W-1:0] held_rs2;
    logic             held_use_imm;
    logic [XLEN-1:0]  fwd_rs1;
    logic [XLEN-1:0]  fwd_rs2;
    logic             capture;

    assign ex_valid = (state == ST_FULL);

    assign load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                            ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && !id_use_imm));

    assign id_ready = (!ex_valid || ex_ready) && !load_use_stall && !flush;
    assign capture  = id_valid && id_ready;

    fwd_mux u_fwd_rs1 (
        .rs            (id_rs1),
        .rf_data       (id_rs1_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .operand       (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs            (id_rs2),
        .rf_data       (id_rs2_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .operand       (fwd_rs2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            ex_aluop     <= ALU_NOP;
            alu_data1    <= '0;
            alu_data2    <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            held_rs1     <= '0;
            held_rs2     <= '0;
            held_use_imm <= 1'b0;
        end else if (flush) begin
            state        <= ST_EMPTY;
            ex_aluop     <= ALU_NOP;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (capture) begin
            state        <= ST_FULL;
            ex_aluop     <= id_aluop;
            alu_data1    <= fwd_rs1;
            alu_data2    <= id_use_imm ? id_imm : fwd_rs2;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            held_rs1     <= id_rs1;
            held_rs2     <= id_rs2;
            held_use_imm <= id_use_imm;
        end else if (ex_valid && !ex_ready) begin
            // a producer may retire while we wait; pick its result up so the operand is not stale
            if (fwd_hit(wb_reg_write, wb_rd, held_rs1)) begin
                alu_data1 <= wb_result;
            end
            if (!held_use_imm && fwd_hit(wb_reg_write, wb_rd, held_rs2)) begin
                alu_data2 <= wb_result;
            end
        end else if (ex_valid) begin
            // drain with nothing captured, which also forms the load-use bubble
            state        <= ST_EMPTY;
            ex_aluop     <= ALU_NOP;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 flush  input  1  kill the held instruction and the ID capture this cycle.
REQ-004 id_valid  input  1  decoded instruction present.
REQ-005 id_ready  output  1  stage accepts an instruction this cycle.
REQ-006 id_aluop  input  4  ALU op code (ALU_AND/OR/ADD/SUB/NOP encodings).
REQ-007 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-008 id_rs1_data, id_rs2_data, id_imm  input  32 each  register-file read data and immediate.
REQ-009 id_use_imm, id_reg_write, id_mem_read  input  1 each  operand-2 select, writeback enable, load flag.
REQ-010 mem_rd, wb_rd  input  5 each  destinations of the MEM and WB stages.
REQ-011 mem_reg_write, wb_reg_write  input  1 each  MEM/WB writeback enables.
REQ-012 mem_result, wb_result  input  32 each  MEM/WB result buses.
REQ-013 ex_ready  input  1  ALU/EX consumer accepts this cycle.
REQ-014 ex_valid  output  1  held instruction valid.
REQ-015 ex_aluop  output  4  registered op code driving the ALU.
REQ-016 alu_data1, alu_data2  output  32 each  registered ALU operands.
REQ-017 ex_rd, ex_reg_write, ex_mem_read  output  5/1/1  registered destination and control.
REQ-018 load_use_stall  output  1  combinational load-use hazard indication.

Function
REQ-019 Two states, EMPTY (ex_valid=0) and FULL (ex_valid=1), SHALL be used.
- Capture: id_valid and id_ready -> FULL.
- Drain: ex_ready with no capture -> EMPTY.
- Stall: FULL and not ex_ready -> hold.
REQ-020 load_use_stall SHALL = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_use_imm)).
REQ-021 id_ready SHALL = (!ex_valid | ex_ready) & !load_use_stall & !flush.
REQ-022 When load_use_stall and ex_ready, the stage SHALL go EMPTY next cycle (bubble) with ex_aluop=ALU_NOP, ex_reg_write=0 and ex_mem_read=0.
REQ-023 Operand forwarding at capture SHALL use this per-source priority:
- MEM: mem_reg_write & mem_rd==rs & rs!=0 -> mem_result.
- else WB: wb_reg_write & wb_rd==rs & rs!=0 -> wb_result.
- else register-file data.
REQ-024 alu_data2 SHALL take id_imm when id_use_imm=1, else the forwarded rs2 value.
REQ-025 Register x0 SHALL never be forwarded; it always reads as the register-file value.
REQ-026 While stalled (FULL, !ex_ready), held alu_data1/alu_data2 SHALL be refreshed from wb_result when wb_reg_write & wb_rd==held rs (nonzero, rs2 only if !use_imm).
- The stage SHALL therefore also store rs1, rs2 and use_imm.
REQ-027 flush SHALL have priority over capture and hold:
- Next cycle ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_aluop=ALU_NOP.
REQ-028 Latency SHALL be 1 cycle from ID acceptance to ex_valid.
REQ-029 Full throughput SHALL be sustained: back-to-back captures with ex_ready=1 and no hazard.
REQ-030 When EMPTY, ex_reg_write and ex_mem_read SHALL read 0.

Reset
REQ-031 With rst=1 at a clock edge, next cycle: ex_valid=0, ex_aluop=ALU_NOP, alu_data1=alu_data2=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
REQ-032 rst SHALL override flush, capture and hold, including mid-stall.
REQ-033 id_ready SHALL be 1 in the cycle after reset if flush=0 and there is no hazard.

Structure
REQ-034 The ALU op encodings SHALL remain in the shared ALU header.
REQ-035 Forward-select constants (FWD_RF, FWD_MEM, FWD_WB) SHALL be in a new shared pipeline header.
REQ-036 One sub-module, fwd_mux (rs, rf_data, MEM/WB buses -> operand), SHALL be instantiated once per source.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Reset then capture ADD, rs1_data=5, imm=7, use_imm=1 -> next cycle ex_valid=1, alu_data1=5, alu_data2=7, ex_aluop=ALU_ADD.
- rs1=3, rf data=1, mem_rd=3/mem_result=0xAA, wb_rd=3/wb_result=0xBB -> alu_data1=0xAA; with rs1=0 -> alu_data1=1.
- FULL with ex_mem_read=1, ex_rd=4; ID rs2=4, use_imm=0 -> load_use_stall=1, id_ready=0, bubble with ex_aluop=ALU_NOP next cycle.
- ex_ready=0 for 3 cycles with wb_rd=held rs1, wb_result=0x55 -> outputs held, alu_data1 becomes 0x55, no capture occurs.
- flush together with id_valid=1 -> next cycle ex_valid=0, ex_reg_write=0.
- rst asserted mid-stall -> all outputs at reset values next cycle.
